// File: rtl/mult_m_dot8.sv
// Signed dot product of two packed N_ELEM x EW operands through a 2-stage pipeline.
// Stage 1 registers the element products; stage 2 registers the wrapped sum byte and overflow flag.
module mult_m_dot8 #(
  parameter int N_ELEM = 10,
  parameter int EW     = 8,
  parameter int OUT_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_ELEM*EW-1:0]   lin,
  input  logic [N_ELEM*EW-1:0]   col,
  output logic [OUT_W-1:0]       n_out,
  output logic                   ovf
);

  localparam int PW = 2 * EW;
  localparam int SW = PW + $clog2(N_ELEM);
  localparam logic signed [SW-1:0] MAX_V = SW'(2 ** (EW - 1) - 1);
  localparam logic signed [SW-1:0] MIN_V = SW'(-(2 ** (EW - 1)));

  logic signed [PW-1:0] prod_d [N_ELEM];
  logic signed [PW-1:0] prod_q [N_ELEM];
  logic signed [SW-1:0] sum_d;
  logic [EW-1:0]        res_d, res_q;
  logic                 ovf_d, ovf_q;

  always_comb begin
    for (int i = 0; i < N_ELEM; i++) begin
      prod_d[i] = PW'($signed(lin[N_ELEM*EW-1-EW*i -: EW])) *
                  PW'($signed(col[N_ELEM*EW-1-EW*i -: EW]));
    end
  end

  // Accumulator is wide enough for the exact sum, so ovf sees no intermediate wrap.
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < N_ELEM; i++) begin
      sum_d = sum_d + SW'(prod_q[i]);
    end
    res_d = sum_d[EW-1:0];
    ovf_d = (sum_d > MAX_V) || (sum_d < MIN_V);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N_ELEM; i++) begin
        prod_q[i] <= '0;
      end
      res_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      for (int i = 0; i < N_ELEM; i++) begin
        prod_q[i] <= prod_d[i];
      end
      res_q <= res_d;
      ovf_q <= ovf_d;
    end
  end

  assign n_out = {res_q, {(OUT_W-EW){1'b0}}};
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_mult_m_dot8.sv
// Directed and random checks of mult_m_dot8 against an integer dot-product model.
module tb_mult_m_dot8;

  logic        clk;
  logic        rst;
  logic [79:0] lin;
  logic [79:0] col;
  logic [31:0] n_out;
  logic        ovf;

  int compared;
  int mismatched;
  int exp_s;
  int pend_s;

  mult_m_dot8 dut (
    .clk  (clk),
    .rst  (rst),
    .lin  (lin),
    .col  (col),
    .n_out(n_out),
    .ovf  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dot(input logic [79:0] a, input logic [79:0] b);
    int s;
    logic signed [7:0] ea, eb;
    s = 0;
    for (int i = 0; i < 10; i++) begin
      ea = a[79-8*i -: 8];
      eb = b[79-8*i -: 8];
      s = s + int'(ea) * int'(eb);
    end
    return s;
  endfunction

  function automatic logic [79:0] mk(input int e0, input int e1, input int e2, input int e3);
    logic [79:0] v;
    v = '0;
    v[79:72] = 8'(e0);
    v[71:64] = 8'(e1);
    v[63:56] = 8'(e2);
    v[55:48] = 8'(e3);
    return v;
  endfunction

  function automatic logic [79:0] rnd();
    logic [79:0] v;
    for (int i = 0; i < 10; i++) v[8*i +: 8] = 8'($urandom);
    return v;
  endfunction

  // One clock: drive at negedge, then the model advances on the edge and outputs are checked.
  task automatic cycle(input logic r, input logic [79:0] l, input logic [79:0] c, input string tag);
    logic [31:0] exp_out;
    logic        exp_ovf;
    @(negedge clk);
    rst = r;
    lin = l;
    col = c;
    @(posedge clk);
    if (!r) begin
      exp_s  = 0;
      pend_s = 0;
    end else begin
      exp_s  = pend_s;
      pend_s = dot(l, c);
    end
    #1;
    exp_out = {8'(exp_s), 24'h0};
    exp_ovf = (exp_s > 127) || (exp_s < -128);
    compared++;
    assert (n_out === exp_out) else begin
      mismatched++;
      $error("FAIL %s n_out: observed %h expected %h", tag, n_out, exp_out);
    end
    compared++;
    assert (ovf === exp_ovf) else begin
      mismatched++;
      $error("FAIL %s ovf: observed %b expected %b", tag, ovf, exp_ovf);
    end
  endtask

  logic [79:0] a0, b0, a1, b1, a2, b2, a3, b3, ra, rb;

  initial begin
    compared   = 0;
    mismatched = 0;
    exp_s      = 0;
    pend_s     = 0;
    rst = 1'b0;
    lin = '0;
    col = '0;

    a0 = mk(2, 3, 4, 5);      b0 = mk(3, 0, 4, 0);
    a1 = mk(2, -3, 4, -5);    b1 = mk(-3, 0, 4, 0);
    a2 = mk(10, 11, 12, 13);  b2 = mk(10, 0, 11, 0);
    a3 = {10{8'h80}};         b3 = {10{8'h80}};

    for (int i = 0; i < 5; i++) cycle(1'b0, rnd(), rnd(), "reset");
    cycle(1'b1, a0, b0, "release0");
    cycle(1'b1, a0, b0, "release1");
    cycle(1'b1, a0, b0, "case22");
    cycle(1'b1, a1, b1, "case22b");
    cycle(1'b1, a1, b1, "case10");
    cycle(1'b1, a2, b2, "case10b");
    cycle(1'b1, a2, b2, "case232");
    cycle(1'b1, a3, b3, "case232b");
    cycle(1'b1, a3, b3, "max");
    cycle(1'b1, a3, {10{8'h7f}}, "max_b");
    cycle(1'b1, a3, {10{8'h7f}}, "min");

    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, a0, b0, "b2b");
      cycle(1'b1, a1, b1, "b2b");
      cycle(1'b1, a2, b2, "b2b");
    end
    cycle(1'b0, a0, b0, "midreset");
    cycle(1'b1, a1, b1, "postreset0");
    cycle(1'b1, a2, b2, "postreset1");
    cycle(1'b1, a2, b2, "postreset2");

    for (int i = 0; i < 200; i++) begin
      ra = rnd();
      rb = rnd();
      if ($urandom_range(0, 3) == 0) begin
        for (int j = 0; j < 10; j++) ra[8*j +: 8] = ($urandom_range(0, 1) == 1) ? 8'h80 : 8'h7f;
      end
      cycle(($urandom_range(0, 19) != 0), ra, rb, "random");
      if ($urandom_range(0, 4) == 0) begin
        cycle(1'b1, ra, rb, "hold");
        cycle(1'b1, ra, rb, "hold");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
